// File: rtl/rot_axi_rd_arb.sv
// ---------------------------------------------------------------------------
// rot_axi_rd_arb
// Two-to-one AXI read-channel arbiter sharing the RoT's single master read
// path. AR requests are arbitrated and registered with a requester-index bit
// prepended to the ID. R beats are routed back combinationally by that bit.
// Per-requester outstanding-burst counters throttle each requester.
// Build option: define ROT_AXI_RD_ARB_RR_EN for round-robin arbitration;
// when it is left undefined, requester 0 has fixed priority.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rot_axi_rd_arb #(
  parameter int IW        = 8,
  parameter int AW        = 64,
  parameter int DW        = 64,
  parameter int MAX_OUTST = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  // requester 0
  input  logic [IW-1:0] s0_ar_id_i,
  input  logic [AW-1:0] s0_ar_addr_i,
  input  logic [7:0]    s0_ar_len_i,
  input  logic          s0_ar_valid_i,
  output logic          s0_ar_ready_o,
  output logic [IW-1:0] s0_r_id_o,
  output logic [DW-1:0] s0_r_data_o,
  output logic [1:0]    s0_r_resp_o,
  output logic          s0_r_last_o,
  output logic          s0_r_valid_o,
  input  logic          s0_r_ready_i,
  // requester 1
  input  logic [IW-1:0] s1_ar_id_i,
  input  logic [AW-1:0] s1_ar_addr_i,
  input  logic [7:0]    s1_ar_len_i,
  input  logic          s1_ar_valid_i,
  output logic          s1_ar_ready_o,
  output logic [IW-1:0] s1_r_id_o,
  output logic [DW-1:0] s1_r_data_o,
  output logic [1:0]    s1_r_resp_o,
  output logic          s1_r_last_o,
  output logic          s1_r_valid_o,
  input  logic          s1_r_ready_i,
  // master port
  output logic [IW:0]   m_ar_id_o,
  output logic [AW-1:0] m_ar_addr_o,
  output logic [7:0]    m_ar_len_o,
  output logic          m_ar_valid_o,
  input  logic          m_ar_ready_i,
  input  logic [IW:0]   m_r_id_i,
  input  logic [DW-1:0] m_r_data_i,
  input  logic [1:0]    m_r_resp_i,
  input  logic          m_r_last_i,
  input  logic          m_r_valid_i,
  output logic          m_r_ready_o,
  output logic          err_unexp_o
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTST);

  typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t     state;
  logic [3:0] cnt0;
  logic [3:0] cnt1;
  logic       elig0;
  logic       elig1;
  logic       grant0;
  logic       grant1;
  logic       in_idle;
  logic       r_sel;
  logic       inc0;
  logic       inc1;
  logic       dec0;
  logic       dec1;

  assign in_idle = (state == ST_IDLE);
  assign elig0   = s0_ar_valid_i && (cnt0 < MAX_CNT);
  assign elig1   = s1_ar_valid_i && (cnt1 < MAX_CNT);

`ifdef ROT_AXI_RD_ARB_RR_EN
  // last_grant = 1 means requester 1 won most recently, so requester 0 wins a tie
  logic last_grant;
  assign grant0 = elig0 && (!elig1 || last_grant);
  assign grant1 = elig1 && !grant0;

  // Track the most recent winner to alternate on ties
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant <= 1'b1;
    end else if (in_idle && (grant0 || grant1)) begin
      last_grant <= grant1;
    end
  end
`else
  assign grant0 = elig0;
  assign grant1 = elig1 && !elig0;
`endif

  // Ready is only offered from IDLE, so m_ar_ready_i never reaches it
  assign s0_ar_ready_o = in_idle && grant0;
  assign s1_ar_ready_o = in_idle && grant1;

  // AR FSM: capture the winner in IDLE, hold it on the master port until accepted
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      m_ar_valid_o <= 1'b0;
      m_ar_id_o    <= '0;
      m_ar_addr_o  <= '0;
      m_ar_len_o   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant0 || grant1) begin
            m_ar_id_o    <= grant1 ? {1'b1, s1_ar_id_i} : {1'b0, s0_ar_id_i};
            m_ar_addr_o  <= grant1 ? s1_ar_addr_i : s0_ar_addr_i;
            m_ar_len_o   <= grant1 ? s1_ar_len_i : s0_ar_len_i;
            m_ar_valid_o <= 1'b1;
            state        <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (m_ar_ready_i) begin
            m_ar_valid_o <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // R routing: the prepended ID bit selects the destination requester
  assign r_sel        = m_r_id_i[IW];
  assign m_r_ready_o  = r_sel ? s1_r_ready_i : s0_r_ready_i;
  assign s0_r_valid_o = m_r_valid_i && !r_sel;
  assign s1_r_valid_o = m_r_valid_i && r_sel;
  assign s0_r_id_o    = m_r_id_i[IW-1:0];
  assign s1_r_id_o    = m_r_id_i[IW-1:0];
  assign s0_r_data_o  = m_r_data_i;
  assign s1_r_data_o  = m_r_data_i;
  assign s0_r_resp_o  = m_r_resp_i;
  assign s1_r_resp_o  = m_r_resp_i;
  assign s0_r_last_o  = m_r_last_i;
  assign s1_r_last_o  = m_r_last_i;

  assign inc0 = s0_ar_valid_i && s0_ar_ready_o;
  assign inc1 = s1_ar_valid_i && s1_ar_ready_o;
  assign dec0 = m_r_valid_i && m_r_ready_o && m_r_last_i && !r_sel;
  assign dec1 = m_r_valid_i && m_r_ready_o && m_r_last_i && r_sel;

  // Outstanding-burst counters; a decrement at zero saturates
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt0 <= 4'd0;
      cnt1 <= 4'd0;
    end else begin
      if (inc0 && !dec0) begin
        cnt0 <= cnt0 + 4'd1;
      end else if (dec0 && !inc0 && (cnt0 != 4'd0)) begin
        cnt0 <= cnt0 - 4'd1;
      end
      if (inc1 && !dec1) begin
        cnt1 <= cnt1 + 4'd1;
      end else if (dec1 && !inc1 && (cnt1 != 4'd0)) begin
        cnt1 <= cnt1 - 4'd1;
      end
    end
  end

  // Sticky flag for an R last that has no outstanding burst to retire
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_unexp_o <= 1'b0;
    end else if ((dec0 && (cnt0 == 4'd0)) || (dec1 && (cnt1 == 4'd0))) begin
      err_unexp_o <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: doc/rot_axi_rd_arb.md
# rot_axi_rd_arb

Two-to-one AXI read-channel arbiter that shares the RoT's single 64-bit AXI master read path between two internal requesters, such as a DMA engine and a boot-ROM fetch unit.
- AR requests are arbitrated and registered onto the master port. One extra ID bit is prepended to identify the requester.
- R beats are routed back by that ID bit.
- A per-requester outstanding-burst counter throttles each requester.
- The block sits between the requesters and the unwrapped master AR/R channel of the RoT top.

## Interface
- IW, 8: requester AXI ID width; the master ID width is IW+1.
- AW, 64: address width.
- DW, 64: data width.
- MAX_OUTST, 4: maximum outstanding read bursts per requester (1..15).

Ports (n = 0, 1; one set per requester):
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- sn_ar_id_i  in  IW  requester AR id
- sn_ar_addr_i  in  AW  requester AR address
- sn_ar_len_i  in  8  requester AR burst length
- sn_ar_valid_i  in  1  requester AR valid
- sn_ar_ready_o  out  1  AR accepted from requester n
- sn_r_id_o  out  IW  routed R id (master id with the MSB stripped)
- sn_r_data_o  out  DW  routed R data
- sn_r_resp_o  out  2  routed R response
- sn_r_last_o  out  1  routed R last
- sn_r_valid_o  out  1  routed R valid
- sn_r_ready_i  in  1  requester R ready
- m_ar_id_o  out  IW+1  {requester index, sn_ar_id_i}
- m_ar_addr_o  out  AW  registered AR address
- m_ar_len_o  out  8  registered AR length
- m_ar_valid_o  out  1  master AR valid
- m_ar_ready_i  in  1  master AR ready
- m_r_id_i  in  IW+1  master R id
- m_r_data_i  in  DW  master R data
- m_r_resp_i  in  2  master R response
- m_r_last_i  in  1  master R last
- m_r_valid_i  in  1  master R valid
- m_r_ready_o  out  1  master R ready
- err_unexp_o  out  1  sticky flag: an R last arrived for a requester whose counter was 0

## Operation
- AR FSM states:
  - IDLE: if any requester is eligible, grant one. Eligible means sn_ar_valid_i=1 and cnt_n < MAX_OUTST. Assert sn_ar_ready_o for the granted requester in the same cycle, load the output register, go to HOLD.
  - HOLD: m_ar_valid_o=1 and all m_ar_* outputs are held stable. On m_ar_ready_i=1 go to IDLE. Both sn_ar_ready_o are 0 while in HOLD.
- Arbitration:
  - Round-robin with a last-grant pointer; the pointer resets to 1, so requester 0 wins the first tie.
  - If only one requester is eligible, it is granted regardless of the pointer.
- Counters cnt_n are 4-bit:
  - +1 on sn_ar_valid_i & sn_ar_ready_o.
  - −1 on m_r_valid_i & m_r_ready_o & m_r_last_i with m_r_id_i[IW]=n.
  - Simultaneous increment and decrement leaves the counter unchanged.
  - Decrement at 0 keeps 0 and sets err_unexp_o.
- R routing is combinational:
  - sel = m_r_id_i[IW].
  - sn_r_valid_o = m_r_valid_i & (sel==n).
  - m_r_ready_o = s<sel>_r_ready_i.
  - data, resp, last and stripped id are broadcast to both requesters.
  - R beats from different bursts may interleave; routing is per beat.
- Reset values: m_ar_valid_o=0, m_ar_id_o/addr/len=0, sn_ar_ready_o=0, counters=0, err_unexp_o=0, FSM=IDLE, pointer=1.
- Reset mid-operation: a pending AR in HOLD is dropped and counters clear. Master-side cleanup is the system's responsibility.

## Timing
- AR latency: accepted in cycle N (sn_ar_ready_o=1); m_ar_valid_o=1 from cycle N+1.
- AR throughput: at most one AR every 2 cycles (IDLE→HOLD→IDLE).
- sn_ar_ready_o depends combinationally on sn_ar_valid_i, FSM state and counters. There is no combinational path from m_ar_ready_i to sn_ar_ready_o.
- R path: zero latency. m_r_ready_o depends combinationally on m_r_id_i and sn_r_ready_i.
- The counter update is visible to eligibility in the cycle after the handshake.

## Configuration
- ROT_AXI_RD_ARB_RR_EN defined: round-robin arbitration as described.
- Not defined: fixed priority, requester 0 always wins when both are eligible. The pointer register is removed.
- All other behaviour is identical in both builds.

## Test plan
- Single AR from requester 0: s0 id=0x5, addr=0x1000, len=3, m_ar_ready_i held 1.
  - Expect s0_ar_ready_o=1 in cycle N.
  - Expect m_ar_valid_o=1 with m_ar_id_o=0x005 in cycle N+1, then IDLE.
  - Expect cnt0=1.
- Both requesters valid continuously, m_ar_ready_i=1.
  - Round-robin build: grants alternate 0,1,0,1.
  - Build without the macro: grants are 0,0,0.
- Master AR back-pressure: m_ar_ready_i=0 for 5 cycles.
  - m_ar_* stay stable.
  - Both sn_ar_ready_o stay 0 until the handshake completes.
- Throttle: issue 4 bursts from s1 with no R returned.
  - The 5th s1 request is stalled.
  - s0 is still granted.
  - One R last with id MSB=1 re-enables s1 in the next cycle.
- R routing with back-pressure: m_r_id_i=0x1A3, m_r_valid_i=1, s1_r_ready_i=0.
  - s1_r_valid_o=1, s1_r_id_o=0xA3, m_r_ready_o=0, s0_r_valid_o=0.
- Unexpected R last for requester 0 with cnt0=0.
  - err_unexp_o=1 and stays set.
  - cnt0 stays 0.
  - rst_i pulse clears err_unexp_o.
